// File: rtl/rowhammer_engine.sv
// rowhammer_engine
//   Avalon-MM master that runs one row-hammer experiment per start pulse.
//   It writes a replicated 32-bit pattern to a victim row and then alternately
//   reads two aggressor rows with up to MAX_OUTST reads in flight. It waits for
//   every response, reads the victim back and reports how many bits differ
//   from the pattern.
//
// Ports
//   clk_clk, reset_reset       : clock, asynchronous active-high reset
//   cfg_start                  : start pulse (only honoured in IDLE or DONE)
//   cfg_aggr_a/_b, cfg_victim  : aggressor and victim addresses
//   cfg_pattern, cfg_count     : 32-bit pattern word, hammer iterations
//   status_busy/_done          : run in progress / result valid
//   status_flips               : popcount(victim readback ^ pattern)
//   status_cycles              : saturating HAMMER+DRAIN cycle count
//   status_err                 : sticky, response arrived with nothing pending
//   avm_*                      : Avalon-MM master, burst length 1, no lock
module rowhammer_engine #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 512,
  parameter int CNT_W     = 32,
  parameter int MAX_OUTST = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_aggr_a,
  input  logic [ADDR_W-1:0] cfg_aggr_b,
  input  logic [ADDR_W-1:0] cfg_victim,
  input  logic [31:0]       cfg_pattern,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic              status_busy,
  output logic              status_done,
  output logic [9:0]        status_flips,
  output logic [CNT_W-1:0]  status_cycles,
  output logic              status_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [5:0]        avm_burstcount,
  output logic              avm_lock,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  localparam int OUT_W = 6;

  typedef enum logic [2:0] {
    IDLE, WRITE_V, HAMMER, DRAIN, CHECK, CHECK_WAIT, DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] aggr_a_reg, aggr_b_reg, victim_reg;
  logic [31:0]       pattern_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W:0]    issued_reg;   // one extra bit: target is 2*count
  logic [OUT_W-1:0]  outst_reg;
  logic [9:0]        flips_reg;
  logic [CNT_W-1:0]  cycles_reg;
  logic              err_reg;

  logic [DATA_W-1:0] pattern_wide;
  logic [DATA_W-1:0] diff;
  logic [9:0]        popcount;
  logic [CNT_W:0]    issued_inc;
  logic              start_ok;
  logic              rd_accept;
  logic              rsp_valid;

  assign pattern_wide = {(DATA_W/32){pattern_reg}};
  assign issued_inc   = issued_reg + (CNT_W+1)'(1);
  assign start_ok     = cfg_start && (state_reg == IDLE || state_reg == DONE);
  assign rd_accept    = avm_read && !avm_waitrequest;
  // Responses are only counted against reads we actually issued.
  assign rsp_valid    = avm_readdatavalid && (outst_reg != '0);

  // Commands are decoded from registered state only, so they hold steady
  // for as long as the slave stalls. The only thing that can change during
  // a stall is the outstanding count, and it can only fall.
  always_comb begin
    state_next    = state_reg;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    case (state_reg)
      IDLE: if (cfg_start) state_next = WRITE_V;
      WRITE_V: begin
        avm_write     = 1'b1;
        avm_address   = victim_reg;
        avm_writedata = pattern_wide;
        if (!avm_waitrequest)
          state_next = (count_reg != '0) ? HAMMER : DRAIN;
      end
      HAMMER: begin
        // Even-numbered reads go to A, odd to B.
        avm_address = issued_reg[0] ? aggr_b_reg : aggr_a_reg;
        avm_read    = (outst_reg != OUT_W'(MAX_OUTST));
        if (avm_read && !avm_waitrequest && issued_inc == {count_reg, 1'b0})
          state_next = DRAIN;
      end
      DRAIN: if (outst_reg == '0) state_next = CHECK;
      CHECK: begin
        avm_read    = 1'b1;
        avm_address = victim_reg;
        if (!avm_waitrequest) state_next = CHECK_WAIT;
      end
      CHECK_WAIT: if (avm_readdatavalid) state_next = DONE;
      DONE: if (cfg_start) state_next = WRITE_V;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    diff     = avm_readdata ^ pattern_wide;
    popcount = '0;
    for (int i = 0; i < DATA_W; i++)
      popcount = popcount + 10'(diff[i]);
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_reg   <= IDLE;
      aggr_a_reg  <= '0;
      aggr_b_reg  <= '0;
      victim_reg  <= '0;
      pattern_reg <= '0;
      count_reg   <= '0;
      issued_reg  <= '0;
      outst_reg   <= '0;
      flips_reg   <= '0;
      cycles_reg  <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (start_ok) begin
        aggr_a_reg  <= cfg_aggr_a;
        aggr_b_reg  <= cfg_aggr_b;
        victim_reg  <= cfg_victim;
        pattern_reg <= cfg_pattern;
        count_reg   <= cfg_count;
        issued_reg  <= '0;
        flips_reg   <= '0;
        cycles_reg  <= '0;
      end

      if (state_reg == HAMMER && rd_accept)
        issued_reg <= issued_inc;

      case ({rd_accept, rsp_valid})
        2'b10:   outst_reg <= outst_reg + 6'd1;
        2'b01:   outst_reg <= outst_reg - 6'd1;
        default: outst_reg <= outst_reg;
      endcase

      if (avm_readdatavalid && outst_reg == '0 && state_reg != CHECK_WAIT)
        err_reg <= 1'b1;

      if ((state_reg == HAMMER || state_reg == DRAIN) && cycles_reg != '1)
        cycles_reg <= cycles_reg + CNT_W'(1);

      if (state_reg == CHECK_WAIT && avm_readdatavalid)
        flips_reg <= popcount;
    end
  end

  assign status_busy    = (state_reg != IDLE) && (state_reg != DONE);
  assign status_done    = (state_reg == DONE);
  assign status_flips   = flips_reg;
  assign status_cycles  = cycles_reg;
  assign status_err     = err_reg;
  assign avm_burstcount = 6'd1;
  assign avm_lock       = 1'b0;

endmodule

// File: tb/tb_rowhammer_engine.sv
module tb_rowhammer_engine;
  localparam int AW = 32;
  localparam int DW = 512;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic [AW-1:0] cfg_aggr_a, cfg_aggr_b, cfg_victim;
  logic [31:0]   cfg_pattern;
  logic [CW-1:0] cfg_count;
  logic          status_busy, status_done, status_err;
  logic [9:0]    status_flips;
  logic [CW-1:0] status_cycles;
  logic [AW-1:0] avm_address;
  logic          avm_read, avm_write, avm_lock;
  logic [DW-1:0] avm_writedata, avm_readdata;
  logic [5:0]    avm_burstcount;
  logic          avm_readdatavalid, avm_waitrequest;

  rowhammer_engine #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .MAX_OUTST(8)) dut (
    .clk_clk(clk), .reset_reset(rst), .cfg_start(cfg_start),
    .cfg_aggr_a(cfg_aggr_a), .cfg_aggr_b(cfg_aggr_b), .cfg_victim(cfg_victim),
    .cfg_pattern(cfg_pattern), .cfg_count(cfg_count),
    .status_busy(status_busy), .status_done(status_done),
    .status_flips(status_flips), .status_cycles(status_cycles),
    .status_err(status_err), .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_burstcount(avm_burstcount), .avm_lock(avm_lock),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave model: fixed-latency responder; victim address returns victim_data,
  // everything else returns the replicated pattern.
  typedef struct { int due; logic [DW-1:0] data; } rsp_t;
  rsp_t          rq[$];
  rsp_t          new_rsp;
  logic [31:0]   rd_log[$];
  int            wr_cnt = 0;
  logic [31:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] victim_data;
  logic [31:0]   slave_pat;
  int            lat = 4;
  bit            rand_wait = 0;
  bit            inject = 0;
  int            cyc = 0;
  int            max_out = 0;
  int            stab_errs = 0;
  logic          prev_stall = 1'b0;
  logic          prev_rd, prev_wr;
  logic [31:0]   prev_addr;
  logic [DW-1:0] prev_wdata;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      rq.delete();
      avm_readdatavalid = 1'b0;
      avm_waitrequest   = 1'b0;
      prev_stall        = 1'b0;
      inject            = 0;
    end else begin
      if (inject) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = '0;
        inject            = 0;
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = rq[0].data;
        void'(rq.pop_front());
      end else begin
        avm_readdatavalid = 1'b0;
      end
      if (prev_stall && (avm_read !== prev_rd || avm_write !== prev_wr ||
                         avm_address !== prev_addr || avm_writedata !== prev_wdata))
        stab_errs++;
      avm_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
      prev_stall = (avm_read || avm_write) && avm_waitrequest;
      prev_rd    = avm_read;
      prev_wr    = avm_write;
      prev_addr  = avm_address;
      prev_wdata = avm_writedata;
      if (avm_read && !avm_waitrequest) begin
        rd_log.push_back(avm_address);
        new_rsp.due  = cyc + lat;
        new_rsp.data = (avm_address == cfg_victim) ? victim_data : {16{slave_pat}};
        rq.push_back(new_rsp);
        if (rq.size() > max_out) max_out = rq.size();
      end
      if (avm_write && !avm_waitrequest) begin
        wr_cnt++;
        wr_addr = avm_address;
        wr_data = avm_writedata;
      end
    end
  end

  task automatic start_run(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] v, input logic [31:0] p,
                           input logic [31:0] n, input logic [DW-1:0] vd);
    @(posedge clk); #1;
    cfg_aggr_a = a; cfg_aggr_b = b; cfg_victim = v;
    cfg_pattern = p; cfg_count = n; slave_pat = p; victim_data = vd;
    rd_log.delete(); wr_cnt = 0; max_out = 0; stab_errs = 0;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (status_done) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: done=%0b after %0d cycles, required 1", name, status_done, limit);
    end
    $display("run %s: reads=%0d writes=%0d flips=%0d cycles=%0d err=%0b",
             name, rd_log.size(), wr_cnt, status_flips, status_cycles, status_err);
  endtask

  task automatic test_reset;
    checks++;
    if ({status_busy, status_done, status_err, avm_read, avm_write} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/err/rd/wr=%b required 00000",
               {status_busy, status_done, status_err, avm_read, avm_write});
    end
    checks++;
    if (status_flips !== 10'd0 || status_cycles !== '0) begin
      errors++;
      $display("FAIL reset_status: flips=%0d cycles=%0d required 0 0", status_flips, status_cycles);
    end
    checks++;
    if (avm_address !== '0 || avm_writedata !== '0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h wdata_nonzero=%0b required 0", avm_address, |avm_writedata);
    end
    checks++;
    if (avm_burstcount !== 6'd1 || avm_lock !== 1'b0) begin
      errors++;
      $display("FAIL reset_const: burst=%0d lock=%0b required 1 0", avm_burstcount, avm_lock);
    end
  endtask

  task automatic check_seq3(input string name);
    logic [31:0] exp_seq [7];
    exp_seq = '{32'h100, 32'h200, 32'h100, 32'h200, 32'h100, 32'h200, 32'h180};
    checks++;
    if (rd_log.size() !== 7) begin
      errors++;
      $display("FAIL %s_nreads: got %0d required 7", name, rd_log.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (rd_log[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL %s_addr%0d: got %h required %h", name, i, rd_log[i], exp_seq[i]);
        end
      end
    end
    checks++;
    if (status_flips !== 10'd0 || status_done !== 1'b1 || status_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: flips=%0d done=%0b busy=%0b required 0 1 0",
               name, status_flips, status_done, status_busy);
    end
  endtask

  task automatic test_basic;
    lat = 4; rand_wait = 0;
    start_run(32'h100, 32'h200, 32'h180, 32'hA5A5A5A5, 3, {16{32'hA5A5A5A5}});
    checks++;
    if (status_busy !== 1'b1 || status_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: busy=%0b done=%0b required 1 0", status_busy, status_done);
    end
    // Changing configuration mid-run must not affect the run.
    cfg_aggr_a = 32'h0BAD; cfg_count = 9;
    wait_done("basic", 200);
    checks++;
    if (wr_cnt !== 1 || wr_addr !== 32'h180 || wr_data !== {16{32'hA5A5A5A5}}) begin
      errors++;
      $display("FAIL basic_write: n=%0d addr=%h data_ok=%0b required 1 180 1",
               wr_cnt, wr_addr, wr_data === {16{32'hA5A5A5A5}});
    end
    check_seq3("basic");
    checks++;
    if (status_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_err: got %0b required 0", status_err);
    end
  endtask

  task automatic test_long;
    lat = 20; rand_wait = 0;
    start_run(32'h1000, 32'h3000, 32'h2000, 32'h0F0F0F0F, 1000, {16{32'h0F0F0F0F}});
    wait_done("long", 20000);
    checks++;
    if (max_out !== 8) begin
      errors++;
      $display("FAIL long_outst: max outstanding %0d required 8", max_out);
    end
    checks++;
    if (rd_log.size() !== 2001) begin
      errors++;
      $display("FAIL long_nreads: got %0d required 2001", rd_log.size());
    end
    checks++;
    if (status_cycles < 5000) begin
      errors++;
      $display("FAIL long_cycles: got %0d required >=5000", status_cycles);
    end
    checks++;
    if (status_flips !== 10'd0) begin
      errors++;
      $display("FAIL long_flips: got %0d required 0", status_flips);
    end
  endtask

  task automatic test_waitreq;
    int bad = 0;
    lat = 3; rand_wait = 1;
    start_run(32'h40, 32'h80, 32'h60, 32'h12345678, 20, {16{32'h12345678}});
    wait_done("waitreq", 2000);
    rand_wait = 0;
    checks++;
    if (stab_errs !== 0) begin
      errors++;
      $display("FAIL waitreq_stable: %0d unstable stalls, required 0", stab_errs);
    end
    checks++;
    if (rd_log.size() !== 41 || wr_cnt !== 1) begin
      errors++;
      $display("FAIL waitreq_count: reads=%0d writes=%0d required 41 1", rd_log.size(), wr_cnt);
    end else begin
      for (int i = 0; i < 40; i++)
        if (rd_log[i] !== ((i % 2) ? 32'h80 : 32'h40)) bad++;
      if (rd_log[40] !== 32'h60) bad++;
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL waitreq_order: %0d misplaced addresses, required 0", bad);
      end
    end
  endtask

  task automatic test_flips;
    logic [DW-1:0] m = '0;
    m[0] = 1'b1; m[100] = 1'b1; m[511] = 1'b1;
    lat = 2;
    start_run(32'h10, 32'h30, 32'h20, 32'hDEADBEEF, 2, {16{32'hDEADBEEF}} ^ m);
    wait_done("flips3", 500);
    checks++;
    if (status_flips !== 10'd3) begin
      errors++;
      $display("FAIL flips3: got %0d required 3", status_flips);
    end
    start_run(32'h10, 32'h30, 32'h20, 32'hDEADBEEF, 2, ~{16{32'hDEADBEEF}});
    wait_done("flips512", 500);
    checks++;
    if (status_flips !== 10'd512) begin
      errors++;
      $display("FAIL flips512: got %0d required 512", status_flips);
    end
  endtask

  task automatic test_count0;
    lat = 4;
    start_run(32'h100, 32'h200, 32'h180, 32'hA5A5A5A5, 0, {16{32'hA5A5A5A5}});
    wait_done("count0", 200);
    checks++;
    if (wr_cnt !== 1 || rd_log.size() !== 1 || rd_log[0] !== 32'h180) begin
      errors++;
      $display("FAIL count0_seq: writes=%0d reads=%0d required 1 1 (victim)", wr_cnt, rd_log.size());
    end
    checks++;
    if (status_cycles !== 1) begin
      errors++;
      $display("FAIL count0_cycles: got %0d required 1", status_cycles);
    end
  endtask

  task automatic test_spurious;
    @(posedge clk); #1;
    inject = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (status_err !== 1'b1 || status_done !== 1'b1 || status_flips !== 10'd0) begin
      errors++;
      $display("FAIL spurious_err: err=%0b done=%0b flips=%0d required 1 1 0",
               status_err, status_done, status_flips);
    end
    start_run(32'h100, 32'h200, 32'h180, 32'hA5A5A5A5, 2, {16{32'hA5A5A5A5}});
    wait_done("after_spurious", 300);
    checks++;
    if (status_err !== 1'b1 || status_flips !== 10'd0) begin
      errors++;
      $display("FAIL spurious_sticky: err=%0b flips=%0d required 1 0", status_err, status_flips);
    end
  endtask

  task automatic test_reset_mid;
    lat = 10;
    start_run(32'h100, 32'h200, 32'h180, 32'hA5A5A5A5, 500, {16{32'hA5A5A5A5}});
    repeat (40) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({status_busy, status_done, status_err, avm_read, avm_write} !== 5'b0 ||
        avm_address !== '0 || avm_writedata !== '0 || status_cycles !== '0) begin
      errors++;
      $display("FAIL midreset: busy=%0b done=%0b err=%0b rd=%0b wr=%0b addr=%h cycles=%0d required all 0",
               status_busy, status_done, status_err, avm_read, avm_write, avm_address, status_cycles);
    end
    @(negedge clk); @(negedge clk); #1 rst = 1'b0;
    lat = 4;
    start_run(32'h100, 32'h200, 32'h180, 32'hA5A5A5A5, 3, {16{32'hA5A5A5A5}});
    wait_done("after_reset", 200);
    check_seq3("after_reset");
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0;
    cfg_aggr_a = '0; cfg_aggr_b = '0; cfg_victim = '0; cfg_pattern = '0; cfg_count = '0;
    slave_pat = '0; victim_data = '0; avm_readdata = '0;
    avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    test_reset;
    @(negedge clk); #1 rst = 1'b0;
    test_basic;
    test_long;
    test_waitreq;
    test_flips;
    test_count0;
    test_spurious;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
